// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial add/subtract engine.
//   state_t : controller FSM encoding (IDLE, RUN, DONE)
//   CNT_W   : bit-counter width for a given operand width
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned CNT_W(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder, the only arithmetic in the serial engine.
// Ports:
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | ((a ^ b) & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract engine: one full-adder cell reused over WIDTH
// cycles, LSB first, with valid/ready handshakes on operands and result.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   in_valid, in_ready          : operand handshake (accepts in IDLE only)
//   a_in, b_in, sub, cin        : operands; sub=1 gives A-B, else A+B+cin
//   out_valid, out_ready        : result handshake (held until accepted)
//   sum_out, cout_out, ovf_out  : result, carry out of MSB, signed overflow
//   busy                        : high while an operation is in flight
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             ovf_out,
    output logic             busy
);

    localparam int unsigned CW = CNT_W(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic             c_msb_in;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;

    // The cell always sees the current LSBs and the running carry.
    fa_cell u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // FSM, datapath shifters and registered outputs.
    // sum_out doubles as the result shift register; it is only meaningful
    // while out_valid is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            c_msb_in  <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum_out   <= '0;
            cout_out  <= 1'b0;
            ovf_out   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a_in;
                        // Subtract as A + ~B + 1; cin is ignored then.
                        b_sh     <= sub ? ~b_in : b_in;
                        carry    <= sub | cin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
                    sum_out <= {fa_sum, sum_out[WIDTH-1:1]};
                    carry   <= fa_cout;
                    cnt     <= cnt + CW'(1);
                    // Carry produced by bit WIDTH-2 is the carry into the MSB.
                    if (cnt == CW'(WIDTH - 2)) begin
                        c_msb_in <= fa_cout;
                    end
                    if (cnt == CW'(WIDTH - 1)) begin
                        cout_out  <= fa_cout;
                        ovf_out   <= c_msb_in ^ fa_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8: vector table plus
// hand-written back-pressure, back-to-back and reset-abort sequences.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] e_sum;
        logic         e_cout;
        logic         e_ovf;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum_out;
    logic         cout_out;
    logic         ovf_out;
    logic         busy;

    exp_t        sb[$];
    int          pass_cnt;
    int          total_cnt;
    int unsigned cyc;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .cout_out  (cout_out),
        .ovf_out   (ovf_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic fail_bound(input string name);
        total_cnt++;
        $display("FAIL %s: wait bound expired, required event not seen", name);
    endtask

    // Reference arithmetic via a wide add, independent of any carry chain.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input logic c);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb     = s ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + (W+1)'(s ? 1'b1 : c);
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    // Scoreboard: every result the consumer takes is compared to the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                fail_bound("sb_unexpected_result");
            end else begin
                e = sb.pop_front();
                check("sb_sum",  64'(sum_out),  64'(e.sum));
                check("sb_cout", 64'(cout_out), 64'(e.cout));
                check("sb_ovf",  64'(ovf_out),  64'(e.ovf));
            end
        end
    end

    // Present operands, wait for acceptance, push the expected result.
    task automatic drive_accept(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s, input logic c, input exp_t e);
        bit ok;
        a_in = a; b_in = b; sub = s; cin = c; in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) fail_bound("accept_wait");
        sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count edges from acceptance until out_valid is seen.
    task automatic wait_result(output int lat);
        bit ok;
        ok  = 1'b0;
        lat = 0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #1 lat++;
            if (out_valid) begin ok = 1'b1; break; end
        end
        if (!ok) fail_bound("result_wait");
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("retire_out_valid", 64'(out_valid), 64'(0));
        check("retire_in_ready",  64'(in_ready),  64'(1));
    endtask

    vec_t        vecs[8];
    exp_t        e;
    int          lat;
    int unsigned acc[3];
    bit          seen;
    bit          ok;

    initial begin
        clk = 1'b0; rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a_in = '0; b_in = '0; sub = 1'b0; cin = 1'b0;
        pass_cnt = 0; total_cnt = 0; cyc = 0;

        //           a      b      sub   cin   sum    cout  ovf
        vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[4] = '{8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[7] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};

        #1 rst = 1'b1;
        #3;
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy",      64'(busy),      64'(0));
        check("rst_sum",       64'(sum_out),   64'(0));
        check("rst_cout",      64'(cout_out),  64'(0));
        check("rst_ovf",       64'(ovf_out),   64'(0));
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Directed table, including latency of exactly W edges after accept.
        foreach (vecs[i]) begin
            e.sum = vecs[i].e_sum; e.cout = vecs[i].e_cout; e.ovf = vecs[i].e_ovf;
            drive_accept(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, e);
            check("busy_in_run", 64'(busy), 64'(1));
            wait_result(lat);
            check("latency", 64'(lat), 64'(W));
            retire();
        end

        // Random operands against the wide-add model.
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ra, rb;
            logic         rs, rc;
            ra = W'($urandom); rb = W'($urandom);
            rs = 1'($urandom); rc = 1'($urandom);
            drive_accept(ra, rb, rs, rc, model(ra, rb, rs, rc));
            wait_result(lat);
            retire();
        end

        // Back-pressure: result held while new operands are offered and ignored.
        drive_accept(8'h3C, 8'h15, 1'b0, 1'b1, model(8'h3C, 8'h15, 1'b0, 1'b1));
        wait_result(lat);
        a_in = 8'hFF; b_in = 8'hFF; sub = 1'b1; cin = 1'b0; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_in_ready",  64'(in_ready),  64'(0));
            check("bp_sum",       64'(sum_out),   64'(8'h52));
            check("bp_cout",      64'(cout_out),  64'(0));
            check("bp_ovf",       64'(ovf_out),   64'(0));
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("bp_idle_out_valid", 64'(out_valid), 64'(0));
        check("bp_idle_in_ready",  64'(in_ready),  64'(1));
        check("bp_idle_busy",      64'(busy),      64'(0));
        check("bp_sb_empty",       64'(sb.size()), 64'(0));

        // Back-to-back: both handshakes held high across three operations.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in = 8'h21 * 8'(i + 1); b_in = 8'h5A + 8'(i); sub = 1'(i % 2); cin = 1'b1;
            ok = 1'b0;
            for (int n = 0; n < 50; n++) begin
                @(negedge clk);
                if (in_ready) begin ok = 1'b1; break; end
            end
            if (!ok) fail_bound("b2b_accept_wait");
            sb.push_back(model(a_in, b_in, sub, cin));
            acc[i] = cyc;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (sb.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) fail_bound("b2b_drain_wait");
        check("b2b_spacing_1", 64'(acc[1] - acc[0]), 64'(W + 2));
        check("b2b_spacing_2", 64'(acc[2] - acc[1]), 64'(W + 2));
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Reset in the third RUN cycle aborts with no result.
        drive_accept(8'h12, 8'h34, 1'b0, 1'b0, model(8'h12, 8'h34, 1'b0, 1'b0));
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'(0));
        check("abort_busy",      64'(busy),      64'(0));
        check("abort_in_ready",  64'(in_ready),  64'(1));
        check("abort_sum",       64'(sum_out),   64'(0));
        check("abort_cout",      64'(cout_out),  64'(0));
        check("abort_ovf",       64'(ovf_out),   64'(0));
        sb.delete();
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        repeat (3 * W) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result",    64'(seen),     64'(0));
        check("abort_idle_ready",   64'(in_ready), 64'(1));

        // Recovery after the aborted operation.
        @(posedge clk); #1;
        drive_accept(8'h12, 8'h34, 1'b0, 1'b0, model(8'h12, 8'h34, 1'b0, 1'b0));
        wait_result(lat);
        check("recover_latency", 64'(lat),     64'(W));
        check("recover_sum",     64'(sum_out), 64'(8'h46));
        retire();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
